// File: rtl/alu_sequencer.sv
// Purpose: drives one ALU operation as LOAD_A/LOAD_B/CALC/STATUS bus phases and captures result and status.
// Latency: start accepted at edge k gives a one-cycle done after edge k+4*PHASE_CYCLES.
// Backpressure: start is taken only in IDLE; start while busy or in DONE is dropped, never queued.
module alu_sequencer #(
  parameter int PHASE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [4:0] func,
  input  logic       carry_in,
  output logic [7:0] alu_data_o,
  output logic [7:0] alu_ctrl_o,
  input  logic [7:0] alu_rsp_i,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry_out,
  output logic [1:0] status
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_STATUS = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Phase codes carried on alu_ctrl_o[1:0]
  localparam logic [1:0] PH_LOAD_A = 2'b00;
  localparam logic [1:0] PH_LOAD_B = 2'b01;
  localparam logic [1:0] PH_CALC   = 2'b10;
  localparam logic [1:0] PH_STATUS = 2'b11;

  // Counter value on the last cycle of a phase
  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Operands frozen at acceptance so later input changes cannot reach the bus
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [4:0] func_q;
  logic       cin_q;
  logic [7:0] a_d;
  logic [7:0] b_d;
  logic [4:0] func_d;
  logic       cin_d;

  // Next values of the registered outputs
  logic [7:0] ctrl_d;
  logic [7:0] data_d;
  logic       busy_d;
  logic       done_d;
  logic [7:0] result_d;
  logic       carry_d;
  logic [1:0] status_d;

  logic accept;
  logic phase_end;
  logic in_phase;

  assign accept    = (state_q == S_IDLE) && start;
  assign phase_end = (cnt_q == LAST_CNT);
  assign in_phase  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) ||
                     (state_q == S_CALC)   || (state_q == S_STATUS);

  // State and phase counter register; reset wins over start
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: each bus phase advances once its counter hits the last cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)     state_d = S_LOAD_A;
      S_LOAD_A: if (phase_end) state_d = S_LOAD_B;
      S_LOAD_B: if (phase_end) state_d = S_CALC;
      S_CALC:   if (phase_end) state_d = S_STATUS;
      S_STATUS: if (phase_end) state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase

    // Counter restarts on every state entry and only runs inside bus phases
    if (state_d != state_q) begin
      cnt_d = 4'd0;
    end else if (in_phase) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = 4'd0;
    end
  end

  // Output logic: bus values for the state being entered, plus the two capture points
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    func_d = func_q;
    cin_d  = cin_q;
    if (accept) begin
      a_d    = op_a;
      b_d    = op_b;
      func_d = func;
      cin_d  = carry_in;
    end

    ctrl_d   = 8'h00;
    data_d   = 8'h00;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result;
    carry_d  = carry_out;
    status_d = status;

    unique case (state_d)
      S_LOAD_A: begin
        ctrl_d = {func_d, cin_d, PH_LOAD_A};
        data_d = a_d;
        busy_d = 1'b1;
      end
      S_LOAD_B: begin
        ctrl_d = {func_d, cin_d, PH_LOAD_B};
        data_d = b_d;
        busy_d = 1'b1;
      end
      S_CALC: begin
        ctrl_d = {func_d, cin_d, PH_CALC};
        busy_d = 1'b1;
      end
      S_STATUS: begin
        ctrl_d = {func_d, cin_d, PH_STATUS};
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase

    // The ALU response is only meaningful on the last edge of CALC and STATUS
    if ((state_q == S_CALC) && phase_end) begin
      result_d = alu_rsp_i;
    end
    if ((state_q == S_STATUS) && phase_end) begin
      carry_d  = alu_rsp_i[2];
      status_d = alu_rsp_i[1:0];
    end
  end

  // Datapath register: latched operands and every output, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      func_q     <= 5'h00;
      cin_q      <= 1'b0;
      alu_ctrl_o <= 8'h00;
      alu_data_o <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 8'h00;
      carry_out  <= 1'b0;
      status     <= 2'b00;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      func_q     <= func_d;
      cin_q      <= cin_d;
      alu_ctrl_o <= ctrl_d;
      alu_data_o <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      result     <= result_d;
      carry_out  <= carry_d;
      status     <= status_d;
    end
  end

  // Parameter range guard: the 4-bit counter and the 3-cycle minimum phase
  a_phase_range: assert property (@(posedge clk) (PHASE_CYCLES >= 3) && (PHASE_CYCLES <= 15));

  // done is a single-cycle pulse
  a_done_pulse: assert property (@(posedge clk) disable iff (rst_n) done |=> !done);

  // busy and done never overlap
  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst_n) !(busy && done));

  // The counter never runs past the final phase cycle
  a_cnt_bound: assert property (@(posedge clk) disable iff (rst_n) cnt_q <= LAST_CNT);

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter PHASE_CYCLES, default 3: clock cycles each ALU phase is held on the bus; legal range 3..15.
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst_n  input  1  synchronous, active-high reset; despite the name, 1 = reset.
REQ-004 start  input  1  request one operation; sampled only in IDLE.
REQ-005 op_a  input  8  operand A; captured on accepted start.
REQ-006 op_b  input  8  operand B; captured on accepted start.
REQ-007 func  input  5  ALU function code; captured on accepted start.
REQ-008 carry_in  input  1  ALU carry/borrow in; captured on accepted start.
REQ-009 alu_data_o  output  8  drives the ALU control block's data input.
REQ-010 alu_ctrl_o  output  8  drives the ALU control block's control input: [7:3]=func, [2]=carry_in, [1:0]=phase code.
REQ-011 alu_rsp_i  input  8  ALU control block's output (result or status byte).
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse; result, carry_out and status are valid.
REQ-014 result  output  8  captured ALU result.
REQ-015 carry_out  output  1  captured alu_rsp_i[2] from the STATUS phase.
REQ-016 status  output  2  captured alu_rsp_i[1:0] from the STATUS phase.

Function
REQ-017 States: IDLE, LOAD_A, LOAD_B, CALC, STATUS, DONE.
- Phase codes on alu_ctrl_o[1:0]: LOAD_A=2'b00, LOAD_B=2'b01, CALC=2'b10, STATUS=2'b11.
REQ-018 IDLE: alu_ctrl_o=8'h00, alu_data_o=8'h00, busy=0.
- start=1 latches op_a, op_b, func and carry_in, then moves to LOAD_A.
REQ-019 Each of LOAD_A, LOAD_B, CALC and STATUS lasts exactly PHASE_CYCLES cycles.
- A 4-bit phase counter clears on every state entry.
- The state advances when the counter reaches PHASE_CYCLES-1.
REQ-020 alu_ctrl_o and alu_data_o are registered and constant for the whole phase.
- alu_data_o = latched A in LOAD_A.
- alu_data_o = latched B in LOAD_B.
- alu_data_o = 8'h00 in CALC and STATUS.
REQ-021 The bus in every phase carries latched func and carry_in on alu_ctrl_o[7:2] together with that phase's code.
REQ-022 On the final cycle edge of CALC, result <= alu_rsp_i.
REQ-023 On the final cycle edge of STATUS, carry_out <= alu_rsp_i[2] and status <= alu_rsp_i[1:0].
REQ-024 DONE lasts one cycle: done=1, busy=0, alu_ctrl_o=8'h00, alu_data_o=8'h00; next state is IDLE.
REQ-025 Latency: with start sampled at edge k, done is high in the cycle after edge k+4*PHASE_CYCLES (13 cycles total for default 3).
REQ-026 result, carry_out and status hold their values until the next capture; they are not cleared in IDLE or DONE.
REQ-027 start while busy or in DONE is ignored and not queued.
- start held high continuously triggers back-to-back operations, each separated by one IDLE cycle.
REQ-028 Changes on op_a, op_b, func or carry_in after acceptance have no effect on the operation in flight.
REQ-029 alu_rsp_i is sampled only at the two capture edges; it is ignored at all other times.

Reset
REQ-030 rst_n=1 at a posedge forces IDLE, clears the counter and all latched operands, and sets every output to 0, including result, carry_out, status, busy and done.
REQ-031 Reset mid-operation aborts the operation with no done pulse; start is ignored in any cycle where rst_n=1.

Verification
REQ-032 Bench ALU model and default parameter. op_a=8'h12, op_b=8'h34, func=5'h03, carry_in=1.
- alu_ctrl_o is 8'h1C, then 8'h1D, then 8'h1E, then 8'h1F, 3 cycles each.
- alu_data_o is 8'h12, then 8'h34.
- done occurs 13 cycles after start.
REQ-033 Model returns 8'h5A in CALC and 8'h05 in STATUS.
- Required: result=8'h5A, carry_out=1, status=2'b01, holding after done.
REQ-034 start pulsed in LOAD_B of a running operation; also op_a changed mid-operation.
- Required: single done pulse, and operand bytes unchanged on alu_data_o.
REQ-035 start held high for 40 cycles.
- Required: exactly 3 done pulses, 14 cycles apart.
REQ-036 rst_n=1 for one cycle during CALC.
- Required: IDLE next cycle, all outputs 0, no done pulse; a new start completes normally.
REQ-037 PHASE_CYCLES=5.
- Required: each phase lasts 5 cycles, and start-to-done is 21 cycles.
